imem_fetch_ctrl: RTL and testbench

Sequences a single-port, byte-wide, synchronous-read instruction memory of 2**XLEN bytes. It assembles little-endian 32-bit instructions for the core fetch stage over a valid/ready handshake. It also shares the memory port with a byte-write program loader, such as a UART boot loader. It sits between the core front end and the memory array, and is the only master of the memory port.

---
 rtl/imem_pkg.sv | 6 +
 rtl/imem_fetch_ctrl.sv | 82 ++++++++
 tb/tb_imem_fetch_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// imem_pkg: shared types and constants for the instruction fetch sequencer
package imem_pkg;
    typedef enum logic [1:0] {IDLE, READ, RESP} fetch_state_t;
    localparam int BYTES_PER_INST = 4;
    localparam int CNT_W = 3;
endpackage

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: assembles 32-bit little-endian instructions from a byte-wide sync-read memory shared with a byte loader
module imem_fetch_ctrl
    import imem_pkg::*;
#(
    parameter int XLEN = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    input  logic [31:0]     req_addr,
    output logic            req_ready,
    output logic            rsp_valid,
    output logic [31:0]     rsp_inst,
    output logic [31:0]     rsp_addr,
    input  logic            rsp_ready,
    input  logic            flush,
    input  logic            ld_valid,
    input  logic [31:0]     ld_addr,
    input  logic [7:0]      ld_data,
    output logic            ld_ready,
    output logic [XLEN-1:0] mem_addr,
    output logic            mem_we,
    output logic [7:0]      mem_wdata,
    input  logic [7:0]      mem_rdata
);
    fetch_state_t     state;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0]  base;
    logic [1:0]       lane;

    assign ld_ready  = (state == IDLE) && !flush;
    assign req_ready = (state == IDLE) && !ld_valid && !flush;
    assign mem_we    = ld_valid && ld_ready;
    assign mem_wdata = ld_data;
    assign lane      = 2'(cnt - 1'b1);
    assign mem_addr  = mem_we ? ld_addr[XLEN-1:0] :
                       (state == READ && cnt != CNT_W'(BYTES_PER_INST)) ? base + XLEN'(cnt) : base;

    generate
        if (XLEN < 32) begin : g_unused
            logic unused_ld_hi;
            assign unused_ld_hi = ^ld_addr[31:XLEN];
        end
    endgenerate

    // fetch sequencer: accept, read four bytes with one-cycle data lag, hold response until consumed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            base      <= '0;
            rsp_valid <= 1'b0;
            rsp_inst  <= '0;
            rsp_addr  <= '0;
        end else if (flush) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid && req_ready) begin
                    base     <= req_addr[XLEN-1:0];
                    rsp_addr <= req_addr;
                    cnt      <= '0;
                    state    <= READ;
                end
                READ: begin
                    if (cnt != '0) rsp_inst[{lane, 3'b000} +: 8] <= mem_rdata;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(BYTES_PER_INST)) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                    end
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb_imem_fetch_ctrl: randomized scoreboard bench with directed boundary cases for imem_fetch_ctrl
module tb_imem_fetch_ctrl;
    localparam int XLEN = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = '0;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_inst;
    logic [31:0] rsp_addr;
    logic        rsp_ready = 1'b0;
    logic        flush = 1'b0;
    logic        ld_valid = 1'b0;
    logic [31:0] ld_addr = '0;
    logic [7:0]  ld_data = '0;
    logic        ld_ready;
    logic [XLEN-1:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic prev_v = 1'b0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] inst;
        int          cyc;
    } exp_t;
    exp_t q[$];

    bit   [7:0] mem [256];
    logic [7:0] ref_mem [256];

    always #5 clk = ~clk;

    imem_fetch_ctrl #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_inst(rsp_inst), .rsp_addr(rsp_addr), .rsp_ready(rsp_ready),
        .flush(flush),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // memory array with one-cycle read latency
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    function automatic logic [31:0] fetch_ref(input logic [31:0] a);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = ref_mem[(int'(a[7:0]) + i) % 256];
        return w;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    // monitor: compare every presented response against the head of the scoreboard
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            prev_v = 1'b0;
        end else begin
            if (rsp_valid) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_rsp got rsp_valid=1 expected no response pending");
                end else begin
                    if (!prev_v) begin
                        checks++;
                        if (cyc != q[0].cyc + 6) begin
                            errors++;
                            $display("FAIL latency got edge %0d expected edge %0d", cyc, q[0].cyc + 6);
                        end
                    end
                    checks++;
                    if (rsp_inst !== q[0].inst || rsp_addr !== q[0].addr) begin
                        errors++;
                        $display("FAIL rsp got inst %h addr %h expected inst %h addr %h",
                                 rsp_inst, rsp_addr, q[0].inst, q[0].addr);
                    end
                end
            end
            if (q.size() > 0 && (flush || (rsp_valid && rsp_ready))) void'(q.pop_front());
            prev_v = rsp_valid;
            cyc++;
        end
    end

    task automatic step(input logic rv, input logic [31:0] ra, input logic lv, input logic [31:0] la,
                        input logic [7:0] ld, input logic fl, input logic rr);
        logic busy;
        @(negedge clk);
        req_valid = rv; req_addr = ra; ld_valid = lv; ld_addr = la; ld_data = ld;
        flush = fl; rsp_ready = rr;
        #1;
        busy = q.size() != 0;
        chk("ld_ready", 32'(ld_ready), 32'(!busy && !fl));
        chk("req_ready", 32'(req_ready), 32'(!busy && !lv && !fl));
        chk("mem_we", 32'(mem_we), 32'(lv && !busy && !fl));
        if (lv && !busy && !fl) begin
            chk("wr_addr", 32'(mem_addr), 32'(la[7:0]));
            chk("wr_data", 32'(mem_wdata), 32'(ld));
            ref_mem[la[7:0]] = ld;
        end
        if (rv && !busy && !lv && !fl) q.push_back('{ra, fetch_ref(ra), cyc});
    endtask

    task automatic idle(input logic rr);
        step(1'b0, 32'h0, 1'b0, 32'h0, 8'h0, 1'b0, rr);
    endtask

    task automatic wr(input logic [31:0] a, input logic [7:0] d);
        step(1'b0, 32'h0, 1'b1, a, d, 1'b0, 1'b0);
    endtask

    task automatic fetch(input logic [31:0] a);
        step(1'b1, a, 1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (rsp_valid !== 1'b1 && n < 12) begin
            idle(1'b0);
            n++;
        end
        chk("rsp_timeout", 32'(rsp_valid), 32'd1);
    endtask

    initial begin
        logic [31:0] held_inst, held_addr;
        repeat (2) @(negedge clk);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_inst", rsp_inst, 32'd0);
        chk("rst_rsp_addr", rsp_addr, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 256; i++) wr(i, 8'($urandom));

        // basic fetch with address sequence and latency
        wr(32'h10, 8'h13); wr(32'h11, 8'h05); wr(32'h12, 8'hA0); wr(32'h13, 8'h00);
        fetch(32'h10);
        for (int i = 0; i < 4; i++) begin
            idle(1'b0);
            chk("rd_addr", 32'(mem_addr), 32'h10 + i);
            chk("rd_we", 32'(mem_we), 32'd0);
        end
        idle(1'b0);
        chk("basic_pre_valid", 32'(rsp_valid), 32'd0);
        idle(1'b1);
        chk("basic_valid", 32'(rsp_valid), 32'd1);
        chk("basic_inst", rsp_inst, 32'h00A00513);
        chk("basic_addr", rsp_addr, 32'h10);

        // address wrap
        wr(32'hFE, 8'h93); wr(32'hFF, 8'h00); wr(32'h00, 8'h10); wr(32'h01, 8'h00);
        fetch(32'h1FE);
        wait_rsp();
        chk("wrap_inst", rsp_inst, 32'h00100093);
        chk("wrap_addr", rsp_addr, 32'h1FE);
        idle(1'b1);

        // loader priority over fetch
        step(1'b1, 32'h20, 1'b1, 32'h20, 8'hAB, 1'b0, 1'b0);
        step(1'b1, 32'h20, 1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
        wait_rsp();
        chk("prio_lane0", 32'(rsp_inst[7:0]), 32'hAB);
        idle(1'b1);

        // backpressure with a stalled loader
        fetch(32'h43);
        wait_rsp();
        held_inst = rsp_inst;
        held_addr = rsp_addr;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'h0, 1'b1, 32'h44, 8'h5A, 1'b0, 1'b0);
            chk("bp_inst", rsp_inst, held_inst);
            chk("bp_addr", rsp_addr, held_addr);
        end
        step(1'b0, 32'h0, 1'b1, 32'h44, 8'h5A, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b1, 32'h44, 8'h5A, 1'b0, 1'b0);

        // flush at cnt==2, then immediate new request
        fetch(32'h80);
        idle(1'b0);
        idle(1'b0);
        step(1'b0, 32'h0, 1'b0, 32'h0, 8'h0, 1'b1, 1'b0);
        fetch(32'h84);
        wait_rsp();
        chk("flush_new_addr", rsp_addr, 32'h84);
        idle(1'b1);

        // randomized traffic
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 9) == 0, $urandom,
                 8'($urandom), $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 6);
        repeat (12) idle(1'b1);
        chk("drain", 32'(q.size()), 32'd0);

        // asynchronous reset while a response is held
        fetch(32'hC1);
        wait_rsp();
        #2 rst = 1'b1;
        #1;
        chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("arst_rsp_inst", rsp_inst, 32'd0);
        chk("arst_rsp_addr", rsp_addr, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        fetch(32'h30);
        wait_rsp();
        idle(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
